// File: rtl/matmul_pkg.sv
// Shared types for the systolic matrix multiplier.
//   operand_mode_e   : which operand buffer an address generator sweeps (A or B)
//   addr_gen_state_e : operand address generator FSM states
package matmul_pkg;

    typedef enum logic {
        MODE_A = 1'b0,
        MODE_B = 1'b1
    } operand_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } addr_gen_state_e;

endpackage : matmul_pkg

// File: rtl/operand_addr_generator.sv
// Read-address generator for one operand buffer (A or B) of the systolic
// matrix multiplier C[m x p] = A[m x n] * B[n x p].
//
// Loop nest (outer -> inner): rb in [0, m/H), cb in [0, p/W), k in [0, n).
//   A mode: addr = base + rb*n + k
//   B mode: addr = base + cb*n + k
// Offsets rb*n and cb*n are kept in accumulators, so no multiplier is used.
// Address sums wrap modulo 2^BUFFER_ADDRESS_WIDTH.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start_i                 start request, honoured only in IDLE
//   abort_i                 synchronous abort, back to IDLE next cycle
//   mode_i                  0 = A sweep, 1 = B sweep (sampled at start)
//   base_addr_i             buffer base address (sampled at start)
//   m, n, p                 matrix dimensions (sampled at start)
//   addr_o / addr_valid_o   address beat, valid/ready handshake
//   addr_ready_i            consumer accepts addr_o this cycle
//   last_o                  beat carries k == n-1
//   busy_o                  FSM not IDLE
//   done_o                  one-cycle pulse after the final beat is accepted
//   err_o                   one-cycle pulse: illegal dimensions at start
module operand_addr_generator
    import matmul_pkg::*;
#(
    parameter int ARRAY_HEIGHT         = 4,
    parameter int ARRAY_WIDTH          = 4,
    parameter int BUFFER_ADDRESS_WIDTH = 10,
    parameter int DIM_WIDTH            = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start_i,
    input  logic                            abort_i,
    input  logic                            mode_i,
    input  logic [BUFFER_ADDRESS_WIDTH-1:0] base_addr_i,
    input  logic [DIM_WIDTH-1:0]            m,
    input  logic [DIM_WIDTH-1:0]            n,
    input  logic [DIM_WIDTH-1:0]            p,
    output logic [BUFFER_ADDRESS_WIDTH-1:0] addr_o,
    output logic                            addr_valid_o,
    input  logic                            addr_ready_i,
    output logic                            last_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o
);

    localparam int BAW   = BUFFER_ADDRESS_WIDTH;
    localparam int DW    = DIM_WIDTH;
    localparam int H_LOG = $clog2(ARRAY_HEIGHT);
    localparam int W_LOG = $clog2(ARRAY_WIDTH);

    addr_gen_state_e state_q, state_d;
    operand_mode_e   mode_q, mode_d;
    logic [BAW-1:0]  base_q, base_d;
    logic [DW-1:0]   n_q, n_d;
    logic [DW-1:0]   rb_max_q, rb_max_d;   // m/H - 1
    logic [DW-1:0]   cb_max_q, cb_max_d;   // p/W - 1
    logic [DW-1:0]   k_q, k_d;
    logic [DW-1:0]   cb_q, cb_d;
    logic [DW-1:0]   rb_q, rb_d;
    logic [DW-1:0]   a_off_q, a_off_d;     // rb*n
    logic [DW-1:0]   b_off_q, b_off_d;     // cb*n
    logic            err_q, err_d;

    logic            dims_ok;
    logic            k_last;
    logic            cb_last;
    logic            rb_last;
    logic            valid;
    logic [DW-1:0]   off_sel;

    // H and W are powers of two, so divisibility is a low-bit mask test.
    assign dims_ok = (m != '0) && (n != '0) && (p != '0)
                  && ((m & DW'(ARRAY_HEIGHT - 1)) == '0)
                  && ((p & DW'(ARRAY_WIDTH - 1)) == '0);

    assign k_last  = (k_q == n_q - DW'(1));
    assign cb_last = (cb_q == cb_max_q);
    assign rb_last = (rb_q == rb_max_q);
    assign valid   = (state_q == RUN);
    assign off_sel = (mode_q == MODE_B) ? b_off_q : a_off_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        base_d   = base_q;
        n_d      = n_q;
        rb_max_d = rb_max_q;
        cb_max_d = cb_max_q;
        k_d      = k_q;
        cb_d     = cb_q;
        rb_d     = rb_q;
        a_off_d  = a_off_q;
        b_off_d  = b_off_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (dims_ok) begin
                        state_d  = RUN;
                        mode_d   = operand_mode_e'(mode_i);
                        base_d   = base_addr_i;
                        n_d      = n;
                        rb_max_d = (m >> H_LOG) - DW'(1);
                        cb_max_d = (p >> W_LOG) - DW'(1);
                        k_d      = '0;
                        cb_d     = '0;
                        rb_d     = '0;
                        a_off_d  = '0;
                        b_off_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Counters only move on an accepted beat, so addr_o/last_o
                // hold while the consumer stalls.
                if (addr_ready_i) begin
                    if (!k_last) begin
                        k_d = k_q + DW'(1);
                    end else begin
                        k_d = '0;
                        if (!cb_last) begin
                            cb_d    = cb_q + DW'(1);
                            b_off_d = b_off_q + n_q;
                        end else begin
                            cb_d    = '0;
                            b_off_d = '0;
                            if (!rb_last) begin
                                rb_d    = rb_q + DW'(1);
                                a_off_d = a_off_q + n_q;
                            end else begin
                                state_d = FIN;
                            end
                        end
                    end
                end
            end
            FIN: begin
                // A start seen here is deliberately dropped.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides every transition, including the err pulse.
        if (abort_i) begin
            state_d = IDLE;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mode_q   <= MODE_A;
            base_q   <= '0;
            n_q      <= '0;
            rb_max_q <= '0;
            cb_max_q <= '0;
            k_q      <= '0;
            cb_q     <= '0;
            rb_q     <= '0;
            a_off_q  <= '0;
            b_off_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
            n_q      <= n_d;
            rb_max_q <= rb_max_d;
            cb_max_q <= cb_max_d;
            k_q      <= k_d;
            cb_q     <= cb_d;
            rb_q     <= rb_d;
            a_off_q  <= a_off_d;
            b_off_q  <= b_off_d;
            err_q    <= err_d;
        end
    end

    // Address is forced to zero outside RUN so idle outputs stay clean.
    assign addr_o       = valid ? BAW'(DW'(base_q) + off_sel + k_q) : '0;
    assign addr_valid_o = valid;
    assign last_o       = valid && k_last;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == FIN);
    assign err_o        = err_q;

endmodule : operand_addr_generator
